// File: rtl/axi4_lite_rr_arbiter.sv
// Round-robin owner select for the shared AXI4-Lite path.
// Grant is held until done or watchdog release.
module axi4_lite_rr_arbiter #(
  parameter  int MASTER_NUM     = 2,
  parameter  int TIMEOUT_CYCLES = 256,
  localparam int ID_WIDTH       = $clog2(MASTER_NUM)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [MASTER_NUM-1:0] req,
  input  logic                  done,
  output logic [MASTER_NUM-1:0] grant,
  output logic [ID_WIDTH-1:0]   grant_id,
  output logic                  busy,
  output logic                  timeout_err
);

  localparam int CNT_W =
    (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [ID_WIDTH-1:0] LAST_RST =
    ID_WIDTH'(MASTER_NUM - 1);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t                r_state;
  logic [MASTER_NUM-1:0] r_grant;
  logic [ID_WIDTH-1:0]   r_grant_id;
  logic                  r_busy;
  logic                  r_to;
  logic [ID_WIDTH-1:0]   r_last;
  logic [CNT_W-1:0]      r_cnt;

  logic                  w_win_vld;
  logic [ID_WIDTH-1:0]   w_win_idx;
  logic [ID_WIDTH-1:0]   w_idx;
  logic [MASTER_NUM-1:0] w_onehot;
  logic                  w_expire;

  // Scan from the highest offset down so the nearest
  // requester after r_last is the final assignment.
  always_comb begin
    w_win_vld = 1'b0;
    w_win_idx = '0;
    w_idx     = '0;
    for (int k = MASTER_NUM; k >= 1; k--) begin
      w_idx = ID_WIDTH'((int'(r_last) + k) % MASTER_NUM);
      if (req[w_idx]) begin
        w_win_vld = 1'b1;
        w_win_idx = w_idx;
      end
    end
  end

  assign w_onehot = MASTER_NUM'(1) << w_win_idx;
  assign w_expire = (TIMEOUT_CYCLES > 0) && (r_cnt == CNT_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_grant    <= '0;
      r_grant_id <= '0;
      r_busy     <= 1'b0;
      r_to       <= 1'b0;
      r_last     <= LAST_RST;
      r_cnt      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_to  <= 1'b0;
          r_cnt <= '0;
          if (w_win_vld) begin
            r_state    <= BUSY;
            r_grant    <= w_onehot;
            r_grant_id <= w_win_idx;
            r_busy     <= 1'b1;
          end
        end
        BUSY: begin
          if (done || w_expire) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_busy  <= 1'b0;
            r_last  <= r_grant_id;
            r_cnt   <= '0;
            r_to    <= !done;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign grant       = r_grant;
  assign grant_id    = r_grant_id;
  assign busy        = r_busy;
  assign timeout_err = r_to;

  a_onehot: assert property (@(posedge clk)
    $onehot0(r_grant));
  a_busy: assert property (@(posedge clk)
    r_busy == (|r_grant));
  a_to_rel: assert property (@(posedge clk)
    r_to |-> !r_busy);

endmodule

// File: tb/tb_axi4_lite_rr_arbiter.sv
// Directed scoreboard bench for axi4_lite_rr_arbiter,
// three masters and an 8-cycle watchdog.
module tb_axi4_lite_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] req;
  logic       done;
  logic [2:0] grant;
  logic [1:0] grant_id;
  logic       busy;
  logic       timeout_err;

  axi4_lite_rr_arbiter #(
    .MASTER_NUM(3),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .done(done),
    .grant(grant),
    .grant_id(grant_id),
    .busy(busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] g;
    logic [1:0] id;
    logic       to;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  task automatic chk(input string nm, input logic [3:0] act,
                     input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h",
               nm, cyc, act, exp);
    end
  endtask

  // Monitor: each edge's outputs against the oldest expectation.
  always @(posedge clk) begin
    exp_t e;
    #1;
    cyc++;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("grant", {1'b0, grant}, {1'b0, e.g});
      chk("busy", {3'b0, busy}, {3'b0, (e.g != 3'b0)});
      chk("timeout_err", {3'b0, timeout_err}, {3'b0, e.to});
      if (e.g != 3'b0)
        chk("grant_id", {2'b0, grant_id}, {2'b0, e.id});
    end
  end

  // Drive one cycle; expectation is for the outputs after this edge.
  task automatic c(input logic [2:0] r, input logic d,
                   input logic rs, input logic [2:0] g,
                   input logic [1:0] id, input logic to);
    exp_t e;
    req  = r;
    done = d;
    rst  = rs;
    e.g  = g;
    e.id = id;
    e.to = to;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst  = 1'b1;
    req  = 3'b000;
    done = 1'b0;
    @(negedge clk);

    // reset
    c(3'b000, 0, 1, 3'b000, 0, 0);
    c(3'b111, 0, 1, 3'b000, 0, 0);
    c(3'b000, 0, 0, 3'b000, 0, 0);

    // strict rotation with all requesting
    c(3'b111, 0, 0, 3'b001, 0, 0);
    c(3'b111, 0, 0, 3'b001, 0, 0);
    c(3'b111, 1, 0, 3'b000, 0, 0);
    c(3'b111, 0, 0, 3'b010, 1, 0);
    c(3'b111, 1, 0, 3'b000, 0, 0);
    c(3'b111, 0, 0, 3'b100, 2, 0);
    c(3'b111, 1, 0, 3'b000, 0, 0);
    c(3'b111, 0, 0, 3'b001, 0, 0);
    c(3'b000, 1, 0, 3'b000, 0, 0);
    c(3'b000, 0, 0, 3'b000, 0, 0);

    // single requester master 2
    for (int n = 0; n < 2; n++) begin
      c(3'b100, 0, 0, 3'b100, 2, 0);
      c(3'b100, 0, 0, 3'b100, 2, 0);
      c(3'b100, 0, 0, 3'b100, 2, 0);
      c(3'b100, 1, 0, 3'b000, 0, 0);
    end
    c(3'b000, 0, 0, 3'b000, 0, 0);

    // req changes while busy
    c(3'b010, 0, 0, 3'b010, 1, 0);
    c(3'b000, 0, 0, 3'b010, 1, 0);
    c(3'b101, 0, 0, 3'b010, 1, 0);
    c(3'b101, 1, 0, 3'b000, 0, 0);
    c(3'b000, 0, 0, 3'b000, 0, 0);

    // watchdog release of master 0, then master 1 wins
    c(3'b011, 0, 0, 3'b001, 0, 0);
    for (int n = 0; n < 7; n++)
      c(3'b011, 0, 0, 3'b001, 0, 0);
    c(3'b011, 0, 0, 3'b000, 0, 1);
    c(3'b011, 0, 0, 3'b010, 1, 0);

    // done coincident with watchdog expiry
    for (int n = 0; n < 7; n++)
      c(3'b011, 0, 0, 3'b010, 1, 0);
    c(3'b011, 1, 0, 3'b000, 0, 0);

    // done in idle is ignored
    c(3'b000, 1, 0, 3'b000, 0, 0);
    c(3'b000, 1, 0, 3'b000, 0, 0);

    // reset mid-busy clears the pointer
    c(3'b111, 0, 0, 3'b100, 2, 0);
    c(3'b111, 0, 0, 3'b100, 2, 0);
    c(3'b111, 0, 1, 3'b000, 0, 0);
    c(3'b111, 0, 0, 3'b001, 0, 0);
    c(3'b111, 1, 0, 3'b000, 0, 0);
    c(3'b000, 0, 0, 3'b000, 0, 0);

    for (int i = 0; i < 10 && sb.size() > 0; i++)
      @(posedge clk);
    #2;
    if (sb.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d left expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
